e203_icb_reg_target: RTL and testbench

ICB responder that terminates one system ICB initiator port of the SoC subsystem (sysper, sysfio or sysmem) with a bank of memory-mapped 32-bit registers. It accepts ICB commands, performs byte-masked writes and reads, flags unmapped, misaligned or read-only-violating accesses with `rsp_err`, and returns in-order responses through a small response buffer. The block replaces the tie-off loopback on a subsystem ICB port so firmware has real targets for bring-up and debug.

---
 rtl/e203_icb_reg_target_pkg.sv | 16 +
 rtl/e203_icb_rsp_fifo.sv | 91 +++++++++
 rtl/e203_icb_reg_target.sv | 107 ++++++++++
 tb/tb_e203_icb_reg_target.sv | 207 ++++++++++++++++++++
 4 files changed

// File: rtl/e203_icb_reg_target_pkg.sv
// Shared ICB widths, response entry type and default base address
// for the ICB register target and its response FIFO.
package e203_icb_reg_target_pkg;

  localparam int ICB_AW = 32;
  localparam int ICB_DW = 32;
  localparam int ICB_MW = 4;

  localparam logic [ICB_AW-1:0] DEF_BASE_ADDR = 32'h1000_0000;

  typedef struct packed {
    logic              err;
    logic [ICB_DW-1:0] rdata;
  } icb_rsp_t;

endpackage

// File: rtl/e203_icb_rsp_fifo.sv
// In-order response FIFO with a registered head entry.
// Ports: push/data in, pop in, full/empty out, head entry out.
module e203_icb_rsp_fifo
  import e203_icb_reg_target_pkg::*;
#(
  parameter int RSP_DEPTH = 2
) (
  input  logic     clk,
  input  logic     rst_n,
  input  logic     i_push,
  input  icb_rsp_t i_data,
  input  logic     i_pop,
  output logic     o_full,
  output logic     o_empty,
  output icb_rsp_t o_head
);

  localparam int AW = (RSP_DEPTH > 1) ? $clog2(RSP_DEPTH) : 1;
  localparam int CW = $clog2(RSP_DEPTH + 1);

  icb_rsp_t      r_mem [RSP_DEPTH];
  logic [AW-1:0] r_wp;
  logic [AW-1:0] r_rp;
  logic [CW-1:0] r_cnt;
  logic          r_full;
  logic          r_empty;
  icb_rsp_t      r_head;

  logic          w_push;
  logic          w_pop;
  logic [AW-1:0] w_wp_nx;
  logic [AW-1:0] w_rp_nx;
  logic [CW-1:0] w_cnt_nx;
  icb_rsp_t      w_head_nx;

  function automatic logic [AW-1:0] ptr_inc(
    input logic [AW-1:0] p
  );
    if (RSP_DEPTH == 1) return '0;
    return p + AW'(1);
  endfunction

  always_comb begin
    w_push   = i_push && !r_full;
    w_pop    = i_pop && !r_empty;
    w_wp_nx  = w_push ? ptr_inc(r_wp) : r_wp;
    w_rp_nx  = w_pop ? ptr_inc(r_rp) : r_rp;
    w_cnt_nx = r_cnt + CW'(w_push) - CW'(w_pop);
    // Head is precomputed so the outputs come straight from flops;
    // a push into an otherwise drained FIFO becomes the new head.
    w_head_nx = '0;
    if (w_cnt_nx != '0) begin
      if (w_push && (r_wp == w_rp_nx))
        w_head_nx = i_data;
      else
        w_head_nx = r_mem[w_rp_nx];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < RSP_DEPTH; i++)
        r_mem[i] <= '0;
    end else if (w_push) begin
      r_mem[r_wp] <= i_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wp    <= '0;
      r_rp    <= '0;
      r_cnt   <= '0;
      r_full  <= 1'b0;
      r_empty <= 1'b1;
      r_head  <= '0;
    end else begin
      r_wp    <= w_wp_nx;
      r_rp    <= w_rp_nx;
      r_cnt   <= w_cnt_nx;
      r_full  <= (w_cnt_nx == CW'(RSP_DEPTH));
      r_empty <= (w_cnt_nx == '0);
      r_head  <= w_head_nx;
    end
  end

  assign o_full  = r_full;
  assign o_empty = r_empty;
  assign o_head  = r_head;

endmodule

// File: rtl/e203_icb_reg_target.sv
// ICB responder: bank of 32-bit registers plus a read-only access counter.
// Ports: clk/rst_n, ICB cmd (valid/ready/read/addr/wdata/wmask), ICB rsp, reg0_o.
module e203_icb_reg_target
  import e203_icb_reg_target_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR = DEF_BASE_ADDR,
  parameter int          NUM_REGS  = 16,
  parameter int          RSP_DEPTH = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              icb_cmd_valid,
  output logic              icb_cmd_ready,
  input  logic              icb_cmd_read,
  input  logic [ICB_AW-1:0] icb_cmd_addr,
  input  logic [ICB_DW-1:0] icb_cmd_wdata,
  input  logic [ICB_MW-1:0] icb_cmd_wmask,
  output logic              icb_rsp_valid,
  input  logic              icb_rsp_ready,
  output logic              icb_rsp_err,
  output logic [ICB_DW-1:0] icb_rsp_rdata,
  output logic [ICB_DW-1:0] reg0_o
);

  localparam int IW = $clog2(NUM_REGS);

  logic [ICB_DW-1:0] r_regs [NUM_REGS-1];
  logic [ICB_DW-1:0] r_acc_cnt;

  logic              w_full;
  logic              w_empty;
  icb_rsp_t          w_head;
  icb_rsp_t          w_push_data;
  logic              w_acc;
  logic [ICB_AW-1:0] w_off;
  logic              w_inr;
  logic [IW-1:0]     w_idx;
  logic              w_last;
  logic              w_err;
  logic              w_wr;
  logic [ICB_DW-1:0] w_rd;

  always_comb begin
    w_acc  = icb_cmd_valid && !w_full;
    // Unsigned wrap makes addresses below BASE_ADDR fall out of range too.
    w_off  = icb_cmd_addr - BASE_ADDR;
    w_inr  = w_off < ICB_AW'(NUM_REGS * 4);
    w_idx  = w_off[IW+1:2];
    w_last = (w_idx == IW'(NUM_REGS - 1));
    w_err  = !w_inr || (w_off[1:0] != 2'b00) || (!icb_cmd_read && w_last);
    w_wr   = w_acc && !icb_cmd_read && !w_err;
  end

  always_comb begin
    w_rd = '0;
    for (int i = 0; i < NUM_REGS - 1; i++)
      if (w_idx == IW'(i)) w_rd = r_regs[i];
    if (w_last) w_rd = r_acc_cnt;
  end

  always_comb begin
    w_push_data       = '0;
    w_push_data.err   = w_err;
    w_push_data.rdata = (w_err || !icb_cmd_read) ? '0 : w_rd;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_REGS - 1; i++)
        r_regs[i] <= '0;
    end else if (w_wr) begin
      for (int i = 0; i < NUM_REGS - 1; i++)
        if (w_idx == IW'(i))
          for (int b = 0; b < ICB_MW; b++)
            if (icb_cmd_wmask[b])
              r_regs[i][8*b +: 8] <= icb_cmd_wdata[8*b +: 8];
    end
  end

  // Counts every accepted command, errored ones included.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      r_acc_cnt <= '0;
    else if (w_acc)
      r_acc_cnt <= r_acc_cnt + 32'd1;
  end

  e203_icb_rsp_fifo #(
    .RSP_DEPTH (RSP_DEPTH)
  ) u_rsp_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_push  (icb_cmd_valid),
    .i_data  (w_push_data),
    .i_pop   (icb_rsp_ready),
    .o_full  (w_full),
    .o_empty (w_empty),
    .o_head  (w_head)
  );

  assign icb_cmd_ready = !w_full;
  assign icb_rsp_valid = !w_empty;
  assign icb_rsp_err   = w_head.err;
  assign icb_rsp_rdata = w_head.rdata;
  assign reg0_o        = r_regs[0];

endmodule

// File: tb/tb_e203_icb_reg_target.sv
// Directed self-checking bench for e203_icb_reg_target.
// Default parameters: BASE 0x1000_0000, 16 registers, 2-entry buffer.
module tb_e203_icb_reg_target;

  localparam logic [31:0] B = 32'h1000_0000;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        icb_cmd_valid = 1'b0;
  logic        icb_cmd_ready;
  logic        icb_cmd_read = 1'b0;
  logic [31:0] icb_cmd_addr = '0;
  logic [31:0] icb_cmd_wdata = '0;
  logic [3:0]  icb_cmd_wmask = '0;
  logic        icb_rsp_valid;
  logic        icb_rsp_ready = 1'b1;
  logic        icb_rsp_err;
  logic [31:0] icb_rsp_rdata;
  logic [31:0] reg0_o;

  int n_chk = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  e203_icb_reg_target dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .icb_cmd_valid (icb_cmd_valid),
    .icb_cmd_ready (icb_cmd_ready),
    .icb_cmd_read  (icb_cmd_read),
    .icb_cmd_addr  (icb_cmd_addr),
    .icb_cmd_wdata (icb_cmd_wdata),
    .icb_cmd_wmask (icb_cmd_wmask),
    .icb_rsp_valid (icb_rsp_valid),
    .icb_rsp_ready (icb_rsp_ready),
    .icb_rsp_err   (icb_rsp_err),
    .icb_rsp_rdata (icb_rsp_rdata),
    .reg0_o        (reg0_o)
  );

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic drive(input logic rd, input logic [31:0] a,
                       input logic [31:0] wd, input logic [3:0] m);
    icb_cmd_valid = 1'b1;
    icb_cmd_read  = rd;
    icb_cmd_addr  = a;
    icb_cmd_wdata = wd;
    icb_cmd_wmask = m;
  endtask

  // Called at a negedge; returns at the negedge after acceptance.
  task automatic issue(input logic rd, input logic [31:0] a,
                       input logic [31:0] wd, input logic [3:0] m);
    int n = 0;
    drive(rd, a, wd, m);
    while (!icb_cmd_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (!icb_cmd_ready) chk("cmd_timeout", icb_cmd_ready, 1);
    else begin
      @(posedge clk);
      @(negedge clk);
    end
    icb_cmd_valid = 1'b0;
  endtask

  task automatic get_rsp(input string tag, input logic e,
                         input logic [31:0] d);
    int n = 0;
    while (!icb_rsp_valid && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk({tag, "_vld"}, icb_rsp_valid, 1);
    chk({tag, "_lat"}, n, 0);
    chk({tag, "_err"}, icb_rsp_err, e);
    chk({tag, "_rdata"}, icb_rsp_rdata, d);
    @(negedge clk);
  endtask

  task automatic xact(input string tag, input logic rd,
                      input logic [31:0] a, input logic [31:0] wd,
                      input logic [3:0] m, input logic e,
                      input logic [31:0] d);
    issue(rd, a, wd, m);
    get_rsp(tag, e, d);
  endtask

  initial begin
    #12;
    chk("rst_cmd_ready", icb_cmd_ready, 1);
    chk("rst_rsp_valid", icb_rsp_valid, 0);
    chk("rst_rsp_err", icb_rsp_err, 0);
    chk("rst_rsp_rdata", icb_rsp_rdata, 0);
    chk("rst_reg0", reg0_o, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // five commands, then the counter
    xact("w_r0", 0, B + 32'h0, 32'hA5A5_0001, 4'hF, 0, 0);
    xact("w_r2", 0, B + 32'h8, 32'h1234_5678, 4'hF, 0, 0);
    xact("r_r2", 1, B + 32'h8, 0, 0, 0, 32'h1234_5678);
    xact("r_oor", 1, B + 32'h40, 0, 0, 1, 0);
    xact("r_mis", 1, B + 32'h2, 0, 0, 1, 0);
    xact("cnt5", 1, B + 32'h3C, 0, 0, 0, 5);
    chk("reg0_live", reg0_o, 32'hA5A5_0001);

    // back-to-back write then read
    drive(0, B + 32'h4, 32'hDEAD_BEEF, 4'hF);
    @(posedge clk);
    @(negedge clk);
    chk("b2b_w_vld", icb_rsp_valid, 1);
    chk("b2b_w_err", icb_rsp_err, 0);
    chk("b2b_w_rdata", icb_rsp_rdata, 0);
    drive(1, B + 32'h4, 0, 0);
    @(posedge clk);
    @(negedge clk);
    icb_cmd_valid = 1'b0;
    chk("b2b_r_vld", icb_rsp_valid, 1);
    chk("b2b_r_err", icb_rsp_err, 0);
    chk("b2b_r_rdata", icb_rsp_rdata, 32'hDEAD_BEEF);
    @(negedge clk);
    chk("b2b_drained", icb_rsp_valid, 0);

    // partial write, read-only write, no-op write
    xact("pw", 0, B + 32'h4, 32'h1122_3344, 4'b0101, 0, 0);
    xact("pr", 1, B + 32'h4, 0, 0, 0, 32'hDE22_BE44);
    xact("w_ro", 0, B + 32'h3C, 32'hFFFF_FFFF, 4'hF, 1, 0);
    xact("cnt11", 1, B + 32'h3C, 0, 0, 0, 11);
    xact("w_nomask", 0, B + 32'h8, 32'hFFFF_FFFF, 4'h0, 0, 0);
    xact("r_nomask", 1, B + 32'h8, 0, 0, 0, 32'h1234_5678);

    // backpressure: third read must wait for a drain
    icb_rsp_ready = 1'b0;
    drive(1, B + 32'h4, 0, 0);
    @(posedge clk);
    @(negedge clk);
    chk("bp_rdy1", icb_cmd_ready, 1);
    drive(1, B + 32'h8, 0, 0);
    @(posedge clk);
    @(negedge clk);
    chk("bp_rdy2", icb_cmd_ready, 0);
    drive(1, B + 32'h0, 0, 0);
    @(posedge clk);
    @(negedge clk);
    chk("bp_held_rdy", icb_cmd_ready, 0);
    chk("bp_held_rdata", icb_rsp_rdata, 32'hDE22_BE44);
    icb_rsp_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("bp_pop_rdy", icb_cmd_ready, 1);
    chk("bp_rsp2", icb_rsp_rdata, 32'h1234_5678);
    @(posedge clk);
    @(negedge clk);
    icb_cmd_valid = 1'b0;
    chk("bp_rsp3_vld", icb_rsp_valid, 1);
    chk("bp_rsp3", icb_rsp_rdata, 32'hA5A5_0001);
    @(negedge clk);
    xact("cnt17", 1, B + 32'h3C, 0, 0, 0, 17);

    // counter wrap
    force dut.r_acc_cnt = 32'hFFFF_FFFF;
    @(posedge clk);
    @(negedge clk);
    release dut.r_acc_cnt;
    xact("cnt_max", 1, B + 32'h3C, 0, 0, 0, 32'hFFFF_FFFF);
    xact("cnt_wrap", 1, B + 32'h3C, 0, 0, 0, 0);

    // reset with two responses buffered
    icb_rsp_ready = 1'b0;
    issue(1, B + 32'h4, 0, 0);
    issue(1, B + 32'h8, 0, 0);
    chk("pre_rst_full", icb_cmd_ready, 0);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_vld", icb_rsp_valid, 0);
    chk("mid_rst_reg0", reg0_o, 0);
    @(negedge clk);
    rst_n = 1'b1;
    icb_rsp_ready = 1'b1;
    chk("post_rst_rdy", icb_cmd_ready, 1);
    xact("post_rst_cnt", 1, B + 32'h3C, 0, 0, 0, 0);
    xact("post_rst_r1", 1, B + 32'h4, 0, 0, 0, 0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule
